// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and default widths for the descriptor-memory arbiter
package dma_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_BCOUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_CMD  = 2'd3
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        UPD   = 1'b1
    } req_id_e;

endpackage

// File: rtl/dma_desc_mem_arbiter_if.sv
// rtl/dma_desc_mem_arbiter_if.sv - requester and descriptor-memory bus bundle for the arbiter
//
// Signals:
//   fetch_*  : burst-read requester (descriptor fetch)
//   upd_*    : single-beat write requester (status update)
//   avm_*    : shared AVMM master port to descriptor memory
//   busy_o / protocol_err_o : arbiter status
// Modports:
//   slave  : arbiter view (receives requests and memory responses)
//   master : environment view (drives requests and memory responses)
interface dma_desc_mem_arbiter_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BCOUNT_W = 4
);
    logic                  fetch_read_i;
    logic [BCOUNT_W-1:0]   fetch_bcount_i;
    logic [ADDR_W-1:0]     fetch_addr_i;
    logic                  fetch_waitrequest_o;
    logic [DATA_W-1:0]     fetch_rddata_o;
    logic                  fetch_readdatavalid_o;

    logic                  upd_wr_i;
    logic [ADDR_W-1:0]     upd_addr_i;
    logic [DATA_W-1:0]     upd_data_i;
    logic [DATA_W/8-1:0]   upd_be_i;
    logic                  upd_wait_req_o;

    logic                  avm_read_o;
    logic                  avm_write_o;
    logic [ADDR_W-1:0]     avm_addr_o;
    logic [BCOUNT_W-1:0]   avm_bcount_o;
    logic [DATA_W-1:0]     avm_wrdata_o;
    logic [DATA_W/8-1:0]   avm_be_o;
    logic                  avm_waitrequest_i;
    logic [DATA_W-1:0]     avm_rddata_i;
    logic                  avm_readdatavalid_i;

    logic                  busy_o;
    logic                  protocol_err_o;

    modport slave (
        input  fetch_read_i, fetch_bcount_i, fetch_addr_i,
        output fetch_waitrequest_o, fetch_rddata_o, fetch_readdatavalid_o,
        input  upd_wr_i, upd_addr_i, upd_data_i, upd_be_i,
        output upd_wait_req_o,
        output avm_read_o, avm_write_o, avm_addr_o, avm_bcount_o, avm_wrdata_o, avm_be_o,
        input  avm_waitrequest_i, avm_rddata_i, avm_readdatavalid_i,
        output busy_o, protocol_err_o
    );

    modport master (
        output fetch_read_i, fetch_bcount_i, fetch_addr_i,
        input  fetch_waitrequest_o, fetch_rddata_o, fetch_readdatavalid_o,
        output upd_wr_i, upd_addr_i, upd_data_i, upd_be_i,
        input  upd_wait_req_o,
        input  avm_read_o, avm_write_o, avm_addr_o, avm_bcount_o, avm_wrdata_o, avm_be_o,
        output avm_waitrequest_i, avm_rddata_i, avm_readdatavalid_i,
        input  busy_o, protocol_err_o
    );

endinterface

// File: rtl/dma_rr_arb2.sv
// rtl/dma_rr_arb2.sv - two-requester round-robin grant with last_grant register
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   req_fetch        : fetch requester is asking
//   req_upd          : update requester is asking
//   take             : the grant is being consumed this cycle; remember the winner
//   grant_valid      : at least one requester is asking
//   grant_id         : winner (only meaningful when grant_valid)
module dma_rr_arb2
    import dma_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_fetch,
    input  logic    req_upd,
    input  logic    take,
    output logic    grant_valid,
    output req_id_e grant_id
);

    req_id_e last_grant;

    // On a tie, whoever did not win last time goes first.
    always_comb begin
        grant_valid = req_fetch | req_upd;
        grant_id    = FETCH;
        if (req_fetch && req_upd) begin
            grant_id = (last_grant == FETCH) ? UPD : FETCH;
        end else if (req_upd) begin
            grant_id = UPD;
        end
    end

    // Reset to UPD so fetch wins the first tie after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= UPD;
        end else if (take && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/dma_desc_mem_arbiter.sv
// rtl/dma_desc_mem_arbiter.sv - shares the descriptor-memory AVMM port between fetch reads and status writes
//
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   bus    : requester, memory and status signals (slave modport)
// A read grant is held until every burst beat has returned; a write grant
// until the single beat is accepted. Stray readdatavalid outside a read burst
// is dropped and latches protocol_err_o until reset.
module dma_desc_mem_arbiter
    import dma_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BCOUNT_W = DEF_BCOUNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    dma_desc_mem_arbiter_if.slave   bus
);

    // One extra bit so a bcount of 0 can hold the full 2^BCOUNT_W beats.
    localparam logic [BCOUNT_W:0]   MAX_BEATS  = {1'b1, {BCOUNT_W{1'b0}}};
    localparam logic [BCOUNT_W:0]   CNT_ONE    = {{BCOUNT_W{1'b0}}, 1'b1};
    localparam logic [BCOUNT_W-1:0] BCOUNT_ONE = {{(BCOUNT_W-1){1'b0}}, 1'b1};

    arb_state_e          state, state_nxt;
    logic [BCOUNT_W:0]   beat_cnt, beat_cnt_nxt;
    logic [BCOUNT_W:0]   beat_load;
    logic                protocol_err;
    logic                grant_valid;
    req_id_e             grant_id;
    logic                grant_take;

    logic                fetch_wait;
    logic                upd_wait;
    logic                fetch_rdv;
    logic                avm_read;
    logic                avm_write;
    logic [ADDR_W-1:0]   avm_addr;
    logic [BCOUNT_W-1:0] avm_bcount;
    logic [DATA_W-1:0]   avm_wrdata;
    logic [DATA_W/8-1:0] avm_be;

    dma_rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req_fetch   (bus.fetch_read_i),
        .req_upd     (bus.upd_wr_i),
        .take        (grant_take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign beat_load = (bus.fetch_bcount_i == '0) ? MAX_BEATS : {1'b0, bus.fetch_bcount_i};

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        grant_take   = 1'b0;
        fetch_wait   = 1'b1;
        upd_wait     = 1'b1;
        fetch_rdv    = 1'b0;
        avm_read     = 1'b0;
        avm_write    = 1'b0;
        avm_addr     = '0;
        avm_bcount   = '0;
        avm_wrdata   = '0;
        avm_be       = '1;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    state_nxt  = (grant_id == FETCH) ? RD_CMD : WR_CMD;
                end
            end
            RD_CMD: begin
                avm_read   = 1'b1;
                avm_addr   = bus.fetch_addr_i;
                avm_bcount = bus.fetch_bcount_i;
                fetch_wait = bus.avm_waitrequest_i;
                if (!bus.avm_waitrequest_i) begin
                    beat_cnt_nxt = beat_load;
                    state_nxt    = RD_DATA;
                end
            end
            RD_DATA: begin
                fetch_rdv = bus.avm_readdatavalid_i;
                if (bus.avm_readdatavalid_i) begin
                    beat_cnt_nxt = beat_cnt - CNT_ONE;
                    if (beat_cnt == CNT_ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WR_CMD: begin
                avm_write  = 1'b1;
                avm_addr   = bus.upd_addr_i;
                avm_wrdata = bus.upd_data_i;
                avm_be     = bus.upd_be_i;
                avm_bcount = BCOUNT_ONE;
                upd_wait   = bus.avm_waitrequest_i;
                if (!bus.avm_waitrequest_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Any beat arriving when no burst is outstanding is a memory-side error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if (bus.avm_readdatavalid_i && (state != RD_DATA)) begin
            protocol_err <= 1'b1;
        end
    end

    assign bus.fetch_waitrequest_o   = fetch_wait;
    assign bus.fetch_rddata_o        = bus.avm_rddata_i;
    assign bus.fetch_readdatavalid_o = fetch_rdv;
    assign bus.upd_wait_req_o        = upd_wait;
    assign bus.avm_read_o            = avm_read;
    assign bus.avm_write_o           = avm_write;
    assign bus.avm_addr_o            = avm_addr;
    assign bus.avm_bcount_o          = avm_bcount;
    assign bus.avm_wrdata_o          = avm_wrdata;
    assign bus.avm_be_o              = avm_be;
    assign bus.busy_o                = (state != IDLE);
    assign bus.protocol_err_o        = protocol_err;

endmodule

// File: tb/tb_dma_desc_mem_arbiter.sv
// tb/tb_dma_desc_mem_arbiter.sv - directed self-checking bench for dma_desc_mem_arbiter
module tb_dma_desc_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dma_desc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BCOUNT_W(4)) bus ();

    dma_desc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BCOUNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        bus.fetch_read_i        = 1'b0;
        bus.fetch_bcount_i      = '0;
        bus.fetch_addr_i        = '0;
        bus.upd_wr_i            = 1'b0;
        bus.upd_addr_i          = '0;
        bus.upd_data_i          = '0;
        bus.upd_be_i            = '0;
        bus.avm_waitrequest_i   = 1'b0;
        bus.avm_rddata_i        = '0;
        bus.avm_readdatavalid_i = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_busy",   bus.busy_o, 0);
        chk("rst_fwait",  bus.fetch_waitrequest_o, 1);
        chk("rst_uwait",  bus.upd_wait_req_o, 1);
        chk("rst_read",   bus.avm_read_o, 0);
        chk("rst_write",  bus.avm_write_o, 0);
        chk("rst_rdv",    bus.fetch_readdatavalid_o, 0);
        chk("rst_err",    bus.protocol_err_o, 0);
        cyc();
        cyc();
        reset = 1'b1;

        // Fetch-only read, 4 beats
        cyc();
        bus.fetch_read_i   = 1'b1;
        bus.fetch_addr_i   = 32'h100;
        bus.fetch_bcount_i = 4'd4;
        #1;
        chk("t1_idle_read",  bus.avm_read_o, 0);
        chk("t1_idle_fwait", bus.fetch_waitrequest_o, 1);
        cyc();
        #1;
        chk("t1_read",   bus.avm_read_o, 1);
        chk("t1_addr",   bus.avm_addr_o, 32'h100);
        chk("t1_bcount", bus.avm_bcount_o, 4);
        chk("t1_be",     bus.avm_be_o, 4'hF);
        chk("t1_fwait",  bus.fetch_waitrequest_o, 0);
        chk("t1_busy",   bus.busy_o, 1);
        cyc();
        bus.fetch_read_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.avm_readdatavalid_i = 1'b1;
            bus.avm_rddata_i        = 32'hA000 + 32'(i);
            #1;
            chk("t1_rdv",  bus.fetch_readdatavalid_o, 1);
            chk("t1_data", bus.fetch_rddata_o, 32'hA000 + 32'(i));
            if (i == 0) chk("t1_read_once", bus.avm_read_o, 0);
            if (i == 3) chk("t1_busy_last", bus.busy_o, 1);
            cyc();
        end
        bus.avm_readdatavalid_i = 1'b0;
        #1;
        chk("t1_done_busy", bus.busy_o, 0);

        // Update-only write with 3 stall cycles
        bus.upd_wr_i          = 1'b1;
        bus.upd_addr_i        = 32'h20C;
        bus.upd_data_i        = 32'hDEAD_BEEF;
        bus.upd_be_i          = 4'hF;
        bus.avm_waitrequest_i = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_write",  bus.avm_write_o, 1);
            chk("t2_uwait",  bus.upd_wait_req_o, 1);
            chk("t2_addr",   bus.avm_addr_o, 32'h20C);
            chk("t2_wrdata", bus.avm_wrdata_o, 32'hDEAD_BEEF);
            cyc();
        end
        bus.avm_waitrequest_i = 1'b0;
        #1;
        chk("t2_write_acc", bus.avm_write_o, 1);
        chk("t2_uwait_acc", bus.upd_wait_req_o, 0);
        chk("t2_bcount",    bus.avm_bcount_o, 1);
        cyc();
        bus.upd_wr_i = 1'b0;
        #1;
        chk("t2_idle_write", bus.avm_write_o, 0);
        chk("t2_idle_busy",  bus.busy_o, 0);

        // Round-robin alternation after reset
        do_reset();
        bus.fetch_read_i   = 1'b1;
        bus.fetch_addr_i   = 32'h300;
        bus.fetch_bcount_i = 4'd1;
        bus.upd_wr_i       = 1'b1;
        bus.upd_addr_i     = 32'h400;
        bus.upd_data_i     = 32'h1111_2222;
        bus.upd_be_i       = 4'h3;
        #1;
        chk("t3_idle_busy", bus.busy_o, 0);
        cyc();
        #1;
        chk("t3_rd1",      bus.avm_read_o, 1);
        chk("t3_rd1_addr", bus.avm_addr_o, 32'h300);
        chk("t3_rd1_uw",   bus.upd_wait_req_o, 1);
        cyc();
        bus.fetch_read_i        = 1'b0;
        bus.avm_readdatavalid_i = 1'b1;
        bus.avm_rddata_i        = 32'h55;
        #1;
        chk("t3_rdv",      bus.fetch_readdatavalid_o, 1);
        chk("t3_rd_uwait", bus.upd_wait_req_o, 1);
        cyc();
        bus.avm_readdatavalid_i = 1'b0;
        bus.fetch_read_i        = 1'b1;
        bus.fetch_addr_i        = 32'h500;
        #1;
        chk("t3_idle2_busy", bus.busy_o, 0);
        cyc();
        #1;
        chk("t3_wr",      bus.avm_write_o, 1);
        chk("t3_wr_addr", bus.avm_addr_o, 32'h400);
        chk("t3_wr_be",   bus.avm_be_o, 4'h3);
        chk("t3_wr_fw",   bus.fetch_waitrequest_o, 1);
        cyc();
        bus.upd_addr_i = 32'h404;
        #1;
        chk("t3_idle3_busy", bus.busy_o, 0);
        cyc();
        #1;
        chk("t3_rd2",      bus.avm_read_o, 1);
        chk("t3_rd2_wr",   bus.avm_write_o, 0);
        chk("t3_rd2_addr", bus.avm_addr_o, 32'h500);
        cyc();
        bus.fetch_read_i        = 1'b0;
        bus.avm_readdatavalid_i = 1'b1;
        #1;
        chk("t3_rd2_rdv", bus.fetch_readdatavalid_o, 1);
        cyc();
        bus.avm_readdatavalid_i = 1'b0;
        cyc();
        #1;
        chk("t3_wr2",      bus.avm_write_o, 1);
        chk("t3_wr2_addr", bus.avm_addr_o, 32'h404);
        cyc();
        bus.upd_wr_i = 1'b0;

        // bcount = 0 means 16 beats; a 17th is a protocol error
        bus.fetch_read_i   = 1'b1;
        bus.fetch_addr_i   = 32'h600;
        bus.fetch_bcount_i = 4'd0;
        cyc();
        #1;
        chk("t4_read",   bus.avm_read_o, 1);
        chk("t4_bcount", bus.avm_bcount_o, 0);
        cyc();
        bus.fetch_read_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.avm_readdatavalid_i = 1'b1;
            bus.avm_rddata_i        = 32'(i);
            #1;
            chk("t4_beat", bus.fetch_readdatavalid_o, 1);
            cyc();
        end
        #1;
        chk("t4_busy_after16", bus.busy_o, 0);
        chk("t4_drop",         bus.fetch_readdatavalid_o, 0);
        chk("t4_err_before",   bus.protocol_err_o, 0);
        cyc();
        bus.avm_readdatavalid_i = 1'b0;
        #1;
        chk("t4_err", bus.protocol_err_o, 1);

        // Update arrives with 2 read beats outstanding
        do_reset();
        #1;
        chk("t5_err_clr", bus.protocol_err_o, 0);
        bus.fetch_read_i   = 1'b1;
        bus.fetch_addr_i   = 32'h800;
        bus.fetch_bcount_i = 4'd4;
        cyc();
        cyc();
        bus.fetch_read_i        = 1'b0;
        bus.avm_readdatavalid_i = 1'b1;
        cyc();
        cyc();
        bus.upd_wr_i   = 1'b1;
        bus.upd_addr_i = 32'h700;
        bus.upd_data_i = 32'hCAFE_F00D;
        bus.upd_be_i   = 4'hC;
        #1;
        chk("t5_uwait_b3", bus.upd_wait_req_o, 1);
        chk("t5_write_b3", bus.avm_write_o, 0);
        cyc();
        #1;
        chk("t5_uwait_b4", bus.upd_wait_req_o, 1);
        chk("t5_busy_b4",  bus.busy_o, 1);
        cyc();
        bus.avm_readdatavalid_i = 1'b0;
        #1;
        chk("t5_idle_uwait", bus.upd_wait_req_o, 1);
        chk("t5_idle_write", bus.avm_write_o, 0);
        chk("t5_idle_busy",  bus.busy_o, 0);
        cyc();
        #1;
        chk("t5_wr",       bus.avm_write_o, 1);
        chk("t5_wr_uwait", bus.upd_wait_req_o, 0);
        chk("t5_wr_addr",  bus.avm_addr_o, 32'h700);
        chk("t5_wr_data",  bus.avm_wrdata_o, 32'hCAFE_F00D);
        chk("t5_wr_be",    bus.avm_be_o, 4'hC);
        cyc();
        bus.upd_wr_i = 1'b0;

        // Reset mid-burst, then a late beat
        bus.fetch_read_i   = 1'b1;
        bus.fetch_addr_i   = 32'h900;
        bus.fetch_bcount_i = 4'd8;
        cyc();
        cyc();
        bus.fetch_read_i        = 1'b0;
        bus.avm_readdatavalid_i = 1'b1;
        cyc();
        cyc();
        #1;
        chk("t6_fwd", bus.fetch_readdatavalid_o, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_rdv",   bus.fetch_readdatavalid_o, 0);
        chk("t6_rst_busy",  bus.busy_o, 0);
        chk("t6_rst_read",  bus.avm_read_o, 0);
        chk("t6_rst_fwait", bus.fetch_waitrequest_o, 1);
        chk("t6_rst_uwait", bus.upd_wait_req_o, 1);
        bus.avm_readdatavalid_i = 1'b0;
        cyc();
        reset = 1'b1;
        bus.avm_readdatavalid_i = 1'b1;
        #1;
        chk("t6_late_rdv",   bus.fetch_readdatavalid_o, 0);
        chk("t6_err_before", bus.protocol_err_o, 0);
        cyc();
        bus.avm_readdatavalid_i = 1'b0;
        #1;
        chk("t6_err", bus.protocol_err_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
